spi_master: RTL and testbench

- SPI initiator for the slave side of our serial link. Fixed mode 0 (CPOL=0, CPHA=0), 8-bit frames, LSB first.
- Runs on system clock SCLK and generates the serial clock sck at SCLK/(2*CLK_DIV).
- Drives cs_n and mosi, and captures miso into rx_data.
- Host logic starts a transfer with a start/busy/done handshake.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_clk_div.sv | 16 +
 rtl/spi_master.sv | 90 +++++++++
 tb/tb_spi_master.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: state encoding, frame width and mode constants shared by the SPI master
package spi_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_state_t;
  localparam int SPI_DATA_WIDTH = 8;
  localparam bit CPOL = 1'b0;
  localparam bit CPHA = 1'b0;
  localparam bit LSB_FIRST = 1'b1;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: one-cycle tick on the last SCLK cycle of each sck half-period
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic SCLK,
  input  logic reset,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV) + 1;
  logic [CW-1:0] cnt;
  assign tick = en && (cnt == CW'(CLK_DIV - 1));
  always_ff @(posedge SCLK or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (!en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/spi_master.sv
// spi_master: mode 0, LSB-first SPI initiator with start/busy/done handshake
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int CLK_DIV    = 2
) (
  input  logic                  SCLK,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sck,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  spi_state_t state;
  logic [DATA_WIDTH-1:0] tx_shift, rx_shift;
  logic [BW-1:0] bit_cnt;
  logic div_en, tick;
  assign div_en = (state == SETUP) || (state == XFER) || (state == HOLD);
  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .SCLK (SCLK),
    .reset(reset),
    .en   (div_en),
    .tick (tick)
  );
  // bit_cnt counts falling sck edges; the half-period after the last one keeps sck low before HOLD
  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sck      <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          tx_shift <= tx_data;
          cs_n     <= 1'b0;
          mosi     <= tx_data[0];
          busy     <= 1'b1;
          bit_cnt  <= '0;
          state    <= SETUP;
        end
        SETUP: if (tick) begin
          sck      <= 1'b1;
          rx_shift <= {miso, rx_shift[DATA_WIDTH-1:1]};
          state    <= XFER;
        end
        XFER: if (tick) begin
          if (bit_cnt == BW'(DATA_WIDTH)) state <= HOLD;
          else if (sck) begin
            sck     <= 1'b0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt != BW'(DATA_WIDTH - 1)) begin
              tx_shift <= tx_shift >> 1;
              mosi     <= tx_shift[1];
            end
          end else begin
            sck      <= 1'b1;
            rx_shift <= {miso, rx_shift[DATA_WIDTH-1:1]};
          end
        end
        HOLD: if (tick) begin
          cs_n    <= 1'b1;
          mosi    <= 1'b0;
          done    <= 1'b1;
          rx_data <= rx_shift;
          state   <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: random and directed frames against a behavioural SPI slave model, CLK_DIV 2 and 1
module tb_spi_master;
  logic SCLK = 1'b0, reset = 1'b0, clk_on = 1'b0;
  logic [1:0] start = '0, drv = '0, lp = '0;
  logic [1:0] sck, cs_n, mosi, busy, done, miso;
  logic [1:0][7:0] tx_data = '0;
  logic [1:0][7:0] rx_data;
  int n_tests = 0, n_fail = 0, cyc = 0, viol = 0;
  int dcnt0 = 0, dcnt1 = 0;
  assign miso = (lp & mosi) | (~lp & drv);

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) u_a (
    .SCLK(SCLK), .reset(reset), .start(start[0]), .tx_data(tx_data[0]), .rx_data(rx_data[0]),
    .busy(busy[0]), .done(done[0]), .sck(sck[0]), .cs_n(cs_n[0]), .mosi(mosi[0]), .miso(miso[0])
  );
  spi_master #(.DATA_WIDTH(8), .CLK_DIV(1)) u_b (
    .SCLK(SCLK), .reset(reset), .start(start[1]), .tx_data(tx_data[1]), .rx_data(rx_data[1]),
    .busy(busy[1]), .done(done[1]), .sck(sck[1]), .cs_n(cs_n[1]), .mosi(mosi[1]), .miso(miso[1])
  );

  initial begin
    wait (clk_on);
    forever #5 SCLK = ~SCLK;
  end
  always @(posedge SCLK) cyc++;
  always @(negedge SCLK) begin
    if (done[0]) dcnt0++;
    if (done[1]) dcnt1++;
    if (|(sck & cs_n)) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input int u, input string tag);
    chk({tag, "_cs_n"}, 32'(cs_n[u]), 1);
    chk({tag, "_sck"}, 32'(sck[u]), 0);
    chk({tag, "_mosi"}, 32'(mosi[u]), 0);
    chk({tag, "_busy"}, 32'(busy[u]), 0);
    chk({tag, "_done"}, 32'(done[u]), 0);
    chk({tag, "_rx"}, 32'(rx_data[u]), 0);
  endtask

  task automatic wait_done(input int u);
    int c = 0;
    while (!done[u] && c < 200) begin
      @(negedge SCLK);
      c++;
    end
    if (!done[u]) chk("done_timeout", 0, 1);
  endtask

  // slave model: presents sv LSB first while sck is low, junk while sck is high or deselected
  task automatic frame(input int u, input logic [7:0] tx, input logic [7:0] sv,
                       input logic loop, input logic inject);
    int k, d0, rises = 0, falls = 0;
    int cd = (u == 1) ? 1 : 2;
    logic prev = 1'b0, got = 1'b0, inj = 1'b0;
    logic [7:0] bits = '0;
    @(negedge SCLK);
    tx_data[u] = tx;
    start[u] = 1'b1;
    lp[u] = loop;
    d0 = (u == 1) ? dcnt1 : dcnt0;
    @(negedge SCLK);
    start[u] = 1'b0;
    k = cyc;
    tx_data[u] = 8'($urandom);
    for (int c = 0; c < 300 && !got; c++) begin
      if (sck[u] && !prev) begin
        if (rises < 8) bits[rises] = mosi[u];
        rises++;
      end
      if (!sck[u] && prev) falls++;
      prev = sck[u];
      drv[u] = (sck[u] || cs_n[u] || rises > 7) ? 1'($urandom) : sv[rises];
      start[u] = 1'b0;
      if (inject && !inj && rises == 3) begin
        tx_data[u] = 8'hFF;
        start[u] = 1'b1;
        inj = 1'b1;
      end
      if (done[u]) begin
        got = 1'b1;
        chk("latency", 32'(cyc - k), 32'(18 * cd));
        chk("rx_data", 32'(rx_data[u]), 32'(loop ? tx : sv));
        chk("mosi_stream", 32'(bits), 32'(tx));
        chk("sck_rises", 32'(rises), 8);
        chk("sck_falls", 32'(falls), 8);
        chk("busy_at_done", 32'(busy[u]), 1);
        chk("cs_n_at_done", 32'(cs_n[u]), 1);
      end else @(negedge SCLK);
    end
    if (!got) chk("done_timeout", 0, 1);
    start[u] = 1'b0;
    @(negedge SCLK);
    chk("busy_after_done", 32'(busy[u]), 0);
    chk("done_one_cycle", 32'(done[u]), 0);
    repeat (3) @(negedge SCLK);
    chk("no_requeue", 32'(busy[u]), 0);
    chk("done_count", 32'(((u == 1) ? dcnt1 : dcnt0) - d0), 1);
  endtask

  initial begin
    int k, hi, rises;
    logic prev;
    #1 reset = 1'b1;
    #1 chk_idle(0, "rst_a");
    chk_idle(1, "rst_b");
    #1 reset = 1'b0;
    clk_on = 1'b1;
    frame(0, 8'hA5, 8'h00, 1'b1, 1'b0);
    frame(0, 8'hC3, 8'h3C, 1'b0, 1'b0);
    frame(0, 8'h12, 8'h00, 1'b1, 1'b1);
    // reset after the third rising sck of a frame
    @(negedge SCLK);
    tx_data[0] = 8'h77;
    lp[0] = 1'b1;
    start[0] = 1'b1;
    @(negedge SCLK);
    start[0] = 1'b0;
    rises = 0;
    prev = 1'b0;
    for (int c = 0; c < 100 && rises < 3; c++) begin
      @(negedge SCLK);
      if (sck[0] && !prev) rises++;
      prev = sck[0];
    end
    chk("reached_rise3", 32'(rises), 3);
    #1 reset = 1'b1;
    #1 chk_idle(0, "midrst");
    @(negedge SCLK);
    reset = 1'b0;
    frame(0, 8'h5A, 8'h00, 1'b1, 1'b0);
    // CLK_DIV=1, start held high across two frames
    @(negedge SCLK);
    tx_data[1] = 8'h01;
    lp[1] = 1'b1;
    start[1] = 1'b1;
    @(negedge SCLK);
    k = cyc;
    tx_data[1] = 8'h80;
    wait_done(1);
    chk("b2b_lat1", 32'(cyc - k), 18);
    chk("b2b_rx1", 32'(rx_data[1]), 8'h01);
    hi = 0;
    for (int c = 0; c < 10 && cs_n[1]; c++) begin
      hi++;
      @(negedge SCLK);
    end
    chk("b2b_cs_high", 32'(hi), 2);
    k = cyc;
    start[1] = 1'b0;
    wait_done(1);
    chk("b2b_lat2", 32'(cyc - k), 18);
    chk("b2b_rx2", 32'(rx_data[1]), 8'h80);
    repeat (12) frame(0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (4) frame(1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    chk("sck_while_deselected", 32'(viol), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
